tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Run/pause/step controller for the game-tick divider. It replaces the free-running high-order-bit clock with a single-cycle `tick` enable plus a 50 % `phase` square wave, both derived from one system clock. Downstream logic stays in the `in_clk` domain and gates on `tick`. The tick period is selected at run time, and can optionally shorten as the game level rises.

## Interface
- `CNT_W`, 24: period counter width. `BASE_PERIOD` must be < 2^CNT_W.
- `BASE_PERIOD`, 1_000_000: cycles per tick at `speed_sel`=0, level 0.
- `STEP`, 50_000: period reduction per level (only with `TICK_SPEEDUP_EN`).
- `MIN_PERIOD`, 100_000: lower bound on the effective period. Must be ≥ 2.
- `LEVEL_TICKS`, 64: ticks per level increment (only with `TICK_SPEEDUP_EN`).

Ports:
- `in_clk` in 1: system clock, all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; IDLE→RUN.
- `stop` in 1: pulse; any state→IDLE.
- `pause` in 1: level; RUN↔PAUSE.
- `step_req` in 1: 4-phase request for one tick while paused.
- `step_ack` out 1: acknowledge for `step_req`.
- `speed_sel` in 2: base period = `BASE_PERIOD >> speed_sel`.
- `tick` out 1: one-cycle enable pulse.
- `phase` out 1: toggles on every `tick`.
- `running` out 1: high in RUN.
- `level` out 4: current level, saturating at 15.

## Operation
- States: IDLE, RUN, PAUSE. Reset → IDLE.
- All outputs reset low/zero: `tick`, `phase`, `running`, `step_ack`, `level`. Counters reset to 0.
- Assertion of `rst_n` low clears everything immediately, mid-period or mid-handshake.
- **IDLE**
  - `count` held at 0.
  - `start` → RUN. On the same edge, `cur_period` is loaded.
- **RUN**
  - `count` increments each cycle.
  - At the edge where `count == cur_period-1`: `count`←0, `tick`←1, `phase` toggles, and `cur_period` is reloaded.
  - `pause`=1 → PAUSE. If that same edge is also the wrap edge, the tick is still issued.
- **PAUSE**
  - `count` is frozen.
  - `pause`=0 → RUN; counting resumes from the frozen value.
- **Step handshake**
  - `step_req` is serviced only in PAUSE, and only when `step_ack`=0.
  - Service: `tick`←1, `phase` toggles, `step_ack`←1. `count` is unchanged.
  - `step_ack` stays high until `step_req` is sampled low, then clears on the next edge.
  - A new step requires `step_req` to have been low first.
  - In RUN, `step_req` is ignored and `step_ack` stays 0.
- **Stop and simultaneous events**
  - `stop` → IDLE from any state. It clears `count`, `level`, the tick counter and `step_ack`. `phase` is cleared as well.
  - `stop` wins over `start`, `pause` and `step_req` in the same cycle.
  - `start` outside IDLE is ignored.
- **Period rule**
  - `cur_period = max(MIN_PERIOD, (BASE_PERIOD >> speed_sel) - level*STEP)`.
  - Computed in CNT_W+5 bits with a signed comparison, so a negative result is floored to `MIN_PERIOD`.
  - A `speed_sel` change mid-period takes effect only at the next wrap (or the next `start`).
- `running` = (state == RUN), registered.

## Timing
- Tick latency: the first `tick` is high in the cycle exactly `cur_period` cycles after the edge that entered RUN. Subsequent ticks are spaced exactly `cur_period` cycles apart.
- Pause effect: time spent in PAUSE extends the current period by exactly the number of PAUSE cycles.
- Step latency: `tick` and `step_ack` rise on the first edge that samples `step_req`=1 in PAUSE.
- Pulse widths: `tick` is always a single cycle, never two back-to-back. `phase` is registered alongside `tick`.

## Configuration
- Macro: `TICK_SPEEDUP_EN`.
- **Defined:**
  - A tick counter counts every `tick`, including step ticks.
  - On reaching `LEVEL_TICKS`, the tick counter clears and `level` increments, saturating at 15.
  - The new `level` is visible in the cycle after that tick. It affects `cur_period` from the next reload.
- **Undefined:**
  - No tick counter is built.
  - `level` is tied to 0.
  - `cur_period = max(MIN_PERIOD, BASE_PERIOD >> speed_sel)`.

## Test plan
Bench parameters: `BASE_PERIOD`=16, `STEP`=2, `MIN_PERIOD`=4, `LEVEL_TICKS`=2.

1. Reset, then `start`, `speed_sel`=0 → first `tick` 16 cycles after the RUN edge, then every 16 cycles. `phase` toggles on each tick. `running`=1.
2. `speed_sel`=2 changed mid-period → the current period completes at 16 cycles, then ticks arrive every 4 cycles. `stop` with `start` in the same cycle → IDLE and all outputs 0.
3. Pause 10 cycles at `count`=5 → next tick arrives 26 cycles after the previous one. Three step handshakes in PAUSE → exactly 3 single-cycle ticks, each coincident with `step_ack` rising. `step_req` held high yields only one tick.
4. With `TICK_SPEEDUP_EN`: ticks spaced 16,16,14,14,12,12,…,4,4,4; `level` saturates at 15 with the period pinned at 4. Without the macro: constant 16 and `level`=0.
5. `rst_n` low mid-period and during a `step_ack`-high window → all outputs 0 immediately. After release, no tick occurs until `start`.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler
// Run/pause/step controller for the game tick. It produces a single-cycle
// tick enable and a phase square wave from the system clock. The tick
// period is selected at run time. When the level feature is built, the
// period can also shorten as the level rises.
//
// Optional feature macro: TICK_SPEEDUP_EN
//   defined   -> a tick counter is built. The level increases every
//                LEVEL_TICKS ticks and saturates at 15. Each level reduces
//                the period by STEP.
//   undefined -> level is tied to 0.
//
// Ports:
//   in_clk    in   system clock; all state changes on its rising edge
//   rst_n     in   asynchronous, active-low reset
//   start     in   pulse, IDLE -> RUN
//   stop      in   pulse, any state -> IDLE (highest priority)
//   pause     in   level, RUN <-> PAUSE
//   step_req  in   4-phase request for one tick while paused
//   step_ack  out  acknowledge for step_req
//   speed_sel in   base period = BASE_PERIOD >> speed_sel
//   tick      out  one-cycle enable pulse
//   phase     out  toggles on every tick
//   running   out  high while in RUN
//   level     out  current level (0..15)
module tick_scheduler #(
  parameter int CNT_W       = 24,
  parameter int BASE_PERIOD = 1_000_000,
  parameter int STEP        = 50_000,
  parameter int MIN_PERIOD  = 100_000,
  parameter int LEVEL_TICKS = 64
) (
  input  logic       in_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       step_req,
  output logic       step_ack,
  input  logic [1:0] speed_sel,
  output logic       tick,
  output logic       phase,
  output logic       running,
  output logic [3:0] level
);

  // The period arithmetic is 5 bits wider than the counter. This keeps
  // base - level*STEP from wrapping, so the signed compare floors
  // negative results.
  localparam int EXT_W = CNT_W + 5;
  localparam logic [CNT_W-1:0]        BASE_P = CNT_W'(BASE_PERIOD);
  localparam logic signed [EXT_W-1:0] MIN_P  = EXT_W'(MIN_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_running;
  logic              r_tick;
  logic              r_phase;
  logic              r_step_ack;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_cur_period;

  logic signed [EXT_W-1:0] w_base;
  logic signed [EXT_W-1:0] w_dec;
  logic signed [EXT_W-1:0] w_diff;
  logic [CNT_W-1:0]        w_period;
  logic                    w_wrap;
  logic                    w_step_go;

`ifdef TICK_SPEEDUP_EN
  localparam int TC_W = $clog2(LEVEL_TICKS + 1);
  localparam logic [EXT_W-1:0] STEP_P = EXT_W'(STEP);

  logic [TC_W-1:0] r_tick_cnt;
  logic [3:0]      r_level;

  assign w_dec = $signed(EXT_W'(r_level) * STEP_P);
  assign level = r_level;

  // The counter samples the registered tick. This makes a new level visible
  // in the cycle after the tick that caused it.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_level    <= 4'd0;
    end else if (stop) begin
      r_tick_cnt <= '0;
      r_level    <= 4'd0;
    end else if (r_tick) begin
      if (r_tick_cnt == TC_W'(LEVEL_TICKS - 1)) begin
        r_tick_cnt <= '0;
        if (r_level != 4'hF) begin
          r_level <= r_level + 4'd1;
        end
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
    end
  end
`else
  assign w_dec = '0;
  assign level = 4'd0;
`endif

  assign w_base   = $signed({5'd0, BASE_P >> speed_sel});
  assign w_diff   = w_base - w_dec;
  assign w_period = (w_diff < MIN_P) ? MIN_P[CNT_W-1:0] : w_diff[CNT_W-1:0];

  assign w_wrap = (r_state == S_RUN) && (r_count == r_cur_period - 1'b1);
  // A step right after a wrap tick (pause asserted on the wrap edge) is
  // delayed by one cycle. This prevents two back-to-back tick cycles.
  assign w_step_go = (r_state == S_PAUSE) && step_req && !r_step_ack && !r_tick;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (pause)  w_state_next = S_PAUSE;
      S_PAUSE: if (!pause) w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
    if (stop) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == S_RUN);
    end
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_cur_period <= '0;
      r_tick       <= 1'b0;
      r_phase      <= 1'b0;
      r_step_ack   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (stop) begin
        r_count    <= '0;
        r_phase    <= 1'b0;
        r_step_ack <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_count <= '0;
            if (start) begin
              r_cur_period <= w_period;
            end
          end
          S_RUN: begin
            // The pause request on this edge does not suppress the count
            // or a wrap tick.
            if (w_wrap) begin
              r_count      <= '0;
              r_tick       <= 1'b1;
              r_phase      <= ~r_phase;
              r_cur_period <= w_period;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
          S_PAUSE: begin
            if (w_step_go) begin
              r_tick  <= 1'b1;
              r_phase <= ~r_phase;
            end
          end
          default: r_count <= '0;
        endcase

        // The ack is held while the request stays high. Outside PAUSE the
        // ack is forced low.
        if (r_state == S_PAUSE) begin
          if (w_step_go) begin
            r_step_ack <= 1'b1;
          end else if (!step_req) begin
            r_step_ack <= 1'b0;
          end
        end else begin
          r_step_ack <= 1'b0;
        end
      end
    end
  end

  assign tick     = r_tick;
  assign phase    = r_phase;
  assign running  = r_running;
  assign step_ack = r_step_ack;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed testbench for tick_scheduler.
// The bench uses BASE_PERIOD=16, STEP=2, MIN_PERIOD=4 and LEVEL_TICKS=2.
// Expected tick spacing follows TICK_SPEEDUP_EN when that macro is defined.
module tb_tick_scheduler;

  logic       in_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       step_req = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic       step_ack;
  logic       tick;
  logic       phase;
  logic       running;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;

  tick_scheduler #(
    .CNT_W(8),
    .BASE_PERIOD(16),
    .STEP(2),
    .MIN_PERIOD(4),
    .LEVEL_TICKS(2)
  ) dut (
    .in_clk(in_clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .pause(pause),
    .step_req(step_req),
    .step_ack(step_ack),
    .speed_sel(speed_sel),
    .tick(tick),
    .phase(phase),
    .running(running),
    .level(level)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clk1();
    @(posedge in_clk);
    #1;
  endtask

  // Counts rising edges until tick is seen high, with a bound of 200.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      clk1();
      n++;
    end while (tick !== 1'b1 && n < 200);
  endtask

  function automatic int exp_level(input int ticks_done);
    int l;
`ifdef TICK_SPEEDUP_EN
    l = ticks_done / 2;
    if (l > 15) l = 15;
`else
    l = 0;
`endif
    return l;
  endfunction

  function automatic int exp_gap(input int lvl);
    int p;
    p = 16 - 2 * lvl;
    if (p < 4) p = 4;
    return p;
  endfunction

  initial begin
    int n;
    int total;

    // Reset state
    #12;
    check("rst_tick", 32'(tick), 0);
    check("rst_phase", 32'(phase), 0);
    check("rst_running", 32'(running), 0);
    check("rst_ack", 32'(step_ack), 0);
    check("rst_level", 32'(level), 0);
    rst_n = 1'b1;
    clk1();

    // 1: start, speed 0, period 16
    start = 1'b1;
    clk1();
    start = 1'b0;
    check("run_running", 32'(running), 1);
    check("run_tick0", 32'(tick), 0);
    wait_tick(n);
    check("t1_latency", 32'(n), 16);
    check("t1_phase", 32'(phase), 1);
    clk1();
    check("t1_single", 32'(tick), 0);
    wait_tick(n);
    check("t2_gap", 32'(n + 1), 16);
    check("t2_phase", 32'(phase), 0);

    // 2: speed_sel change mid-period applies at the next wrap
    repeat (3) clk1();
    speed_sel = 2'd2;
    wait_tick(n);
    check("t3_gap", 32'(n + 3), 16);
    check("t3_phase", 32'(phase), 1);
    wait_tick(n);
    check("t4_gap", 32'(n), 4);
    wait_tick(n);
    check("t5_gap", 32'(n), 4);
    check("t5_phase", 32'(phase), 1);
    stop = 1'b1;
    start = 1'b1;
    clk1();
    stop = 1'b0;
    start = 1'b0;
    check("stop_running", 32'(running), 0);
    check("stop_tick", 32'(tick), 0);
    check("stop_phase", 32'(phase), 0);
    check("stop_level", 32'(level), 0);
    check("stop_ack", 32'(step_ack), 0);
    total = 0;
    repeat (20) begin
      clk1();
      total += int'(tick);
    end
    check("idle_no_tick", 32'(total), 0);
    check("idle_running", 32'(running), 0);
    speed_sel = 2'd0;

    // 3: pause for 10 cycles at count 5
    start = 1'b1;
    clk1();
    start = 1'b0;
    wait_tick(n);
    check("p_t1_latency", 32'(n), 16);
    repeat (5) clk1();
    pause = 1'b1;
    clk1();
    check("pause_running", 32'(running), 0);
    repeat (9) clk1();
    pause = 1'b0;
    wait_tick(n);
    check("pause_gap", 32'(5 + 10 + n), 26);

    // 3: three step handshakes while paused
    stop = 1'b1;
    clk1();
    stop = 1'b0;
    start = 1'b1;
    clk1();
    start = 1'b0;
    pause = 1'b1;
    clk1();
    check("step_pause_running", 32'(running), 0);
    total = 0;
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      clk1();
      total += int'(tick);
      check("step_tick", 32'(tick), 1);
      check("step_ack_rise", 32'(step_ack), 1);
      repeat (3) begin
        clk1();
        total += int'(tick);
      end
      check("step_ack_hold", 32'(step_ack), 1);
      step_req = 1'b0;
      clk1();
      total += int'(tick);
      check("step_ack_fall", 32'(step_ack), 0);
      clk1();
      total += int'(tick);
    end
    check("step_total", 32'(total), 3);

    // step_req in RUN is ignored
    pause = 1'b0;
    clk1();
    check("resume_running", 32'(running), 1);
    step_req = 1'b1;
    repeat (3) begin
      clk1();
      check("run_step_ack", 32'(step_ack), 0);
      check("run_step_tick", 32'(tick), 0);
    end
    step_req = 1'b0;

    // 4: level progression of the tick spacing
    stop = 1'b1;
    clk1();
    stop = 1'b0;
    start = 1'b1;
    clk1();
    start = 1'b0;
    wait_tick(n);
    check("lv_first", 32'(n), 16);
    for (int k = 1; k <= 34; k++) begin
      check("lv_level", 32'(level), 32'(exp_level(k - 1)));
      wait_tick(n);
      check("lv_gap", 32'(n), 32'(exp_gap(exp_level(k - 1))));
    end
    clk1();
    check("lv_final_level", 32'(level), 32'(exp_level(35)));

    // 5: asynchronous reset mid-period
    repeat (2) clk1();
    rst_n = 1'b0;
    #2;
    check("ar_tick", 32'(tick), 0);
    check("ar_phase", 32'(phase), 0);
    check("ar_running", 32'(running), 0);
    check("ar_level", 32'(level), 0);
    check("ar_ack", 32'(step_ack), 0);
    #2;
    rst_n = 1'b1;
    total = 0;
    repeat (40) begin
      clk1();
      total += int'(tick);
    end
    check("ar_no_tick", 32'(total), 0);
    check("ar_idle", 32'(running), 0);

    // 5: asynchronous reset during the step_ack window
    start = 1'b1;
    clk1();
    start = 1'b0;
    pause = 1'b1;
    clk1();
    step_req = 1'b1;
    clk1();
    check("ar2_ack_pre", 32'(step_ack), 1);
    check("ar2_tick_pre", 32'(tick), 1);
    rst_n = 1'b0;
    #2;
    check("ar2_ack", 32'(step_ack), 0);
    check("ar2_tick", 32'(tick), 0);
    check("ar2_phase", 32'(phase), 0);
    check("ar2_running", 32'(running), 0);
    #2;
    rst_n = 1'b1;
    pause = 1'b0;
    step_req = 1'b0;
    total = 0;
    repeat (40) begin
      clk1();
      total += int'(tick);
    end
    check("ar2_no_tick", 32'(total), 0);
    check("ar2_idle", 32'(running), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
